// File: rtl/alu_sequencer.sv
// Control sequencer for the ALU datapath: accepts one operation per handshake,
// strobes load-A / load-B / latch / read-out, and returns the captured result.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_op,
    output logic [15:0] busOut,
    input  logic [15:0] busIn,
    output logic [2:0]  opControl,
    output logic        ALUin0,
    output logic        ALUin1,
    output logic        ALUOutLatch,
    output logic        ALUOutEn,
    output logic [15:0] ops_done
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // LOAD_A | operand A on busOut, ALUin0 strobe
    // LOAD_B | operand B on busOut, ALUin1 strobe
    // LATCH  | ALUOutLatch strobe
    // READ   | ALUOutEn, busIn captured at the closing edge
    // RESP   | rsp_valid held until rsp_ready
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] LATCH  = 3'd3;
    localparam logic [2:0] READ   = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            rsp_data <= 16'd0;
            rsp_op   <= 3'd0;
            ops_done <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: state <= LOAD_B;
                LOAD_B: state <= LATCH;
                LATCH:  state <= READ;
                READ: begin
                    // busIn is only trusted here; it floats in every other state
                    rsp_data <= busIn;
                    rsp_op   <= op_q;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ops_done <= ops_done + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busOut      = 16'd0;
        opControl   = 3'd0;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        ALUOutLatch = 1'b0;
        ALUOutEn    = 1'b0;
        case (state)
            IDLE:   cmd_ready = 1'b1;
            LOAD_A: begin
                busOut    = a_q;
                opControl = op_q;
                ALUin0    = 1'b1;
            end
            LOAD_B: begin
                busOut    = b_q;
                opControl = op_q;
                ALUin1    = 1'b1;
            end
            LATCH: begin
                opControl   = op_q;
                ALUOutLatch = 1'b1;
            end
            READ: begin
                opControl = op_q;
                ALUOutEn  = 1'b1;
            end
            RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: datapath stub, cycle-level reference model and
// directed plus randomized operations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic [15:0] busOut;
    wire  [15:0] busIn;
    logic [2:0]  opControl;
    logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run_cmp = 0;
    bit rand_rdy = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op),
        .busOut(busOut), .busIn(busIn), .opControl(opControl),
        .ALUin0(ALUin0), .ALUin1(ALUin1),
        .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
        .ops_done(ops_done)
    );

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    alu = a + b;
            3'd1:    alu = a - b;
            3'd2:    alu = a ^ b;
            default: alu = a & b;
        endcase
    endfunction

    // datapath stub
    logic [15:0] ra = 16'd0, rb = 16'd0, rout = 16'd0;
    always @(posedge clk) begin
        if (ALUin0) ra <= busOut;
        if (ALUin1) rb <= busOut;
        if (ALUOutLatch) rout <= alu(opControl, ra, rb);
    end
    assign busIn = ALUOutEn ? rout : 16'hzzzz;

    // reference: ph = cycles elapsed since acceptance (0 idle, 5 waiting on consumer)
    int          ph = 0;
    logic [2:0]  m_op = 0, m_rop = 0;
    logic [15:0] m_a = 0, m_b = 0, m_data = 0, m_cnt = 0;
    logic [15:0] rsp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; m_op = 0; m_rop = 0; m_a = 0; m_b = 0; m_data = 0; m_cnt = 0;
        end else begin
            cyc++;
            if (ph == 0) begin
                if (cmd_valid) begin
                    m_op = cmd_op; m_a = cmd_a; m_b = cmd_b; ph = 1;
                end
            end else if (ph < 4) begin
                ph++;
            end else if (ph == 4) begin
                m_data = alu(m_op, m_a, m_b); m_rop = m_op; ph = 5;
            end else if (rsp_ready) begin
                rsp_q.push_back(m_data);
                m_cnt = m_cnt + 16'd1;
                ph = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("cmd_ready",   {15'd0, cmd_ready},   {15'd0, ph == 0});
            chk("rsp_valid",   {15'd0, rsp_valid},   {15'd0, ph == 5});
            chk("busOut",      busOut, (ph == 1) ? m_a : (ph == 2) ? m_b : 16'd0);
            chk("opControl",   {13'd0, opControl},   {13'd0, (ph >= 1 && ph <= 4) ? m_op : 3'd0});
            chk("ALUin0",      {15'd0, ALUin0},      {15'd0, ph == 1});
            chk("ALUin1",      {15'd0, ALUin1},      {15'd0, ph == 2});
            chk("ALUOutLatch", {15'd0, ALUOutLatch}, {15'd0, ph == 3});
            chk("ALUOutEn",    {15'd0, ALUOutEn},    {15'd0, ph == 4});
            chk("rsp_data",    rsp_data, m_data);
            chk("rsp_op",      {13'd0, rsp_op},      {13'd0, m_rop});
            chk("ops_done",    ops_done, m_cnt);
        end
    end

    task automatic tick(output bit acc);
        @(posedge clk);
        acc = cmd_valid && cmd_ready;
        #2;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        bit d;
        for (int i = 0; i < n; i++) tick(d);
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output int t);
        bit acc;
        acc = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 60 && !acc; i++) tick(acc);
        t = acc ? cyc : -1;
        if (!acc) chk("send_timeout", 16'd0, 16'd1);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    endtask

    task automatic drain();
        rand_rdy = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && ph != 0; i++) ticks(1);
        chk("drain_idle", {15'd0, ph == 0}, 16'd1);
    endtask

    initial begin
        int t0, t1, n0;
        ticks(2);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_rsp_data", rsp_data, 16'd0);
        chk("rst_ops_done", ops_done, 16'd0);
        chk("rst_strobes", {12'd0, ALUin0, ALUin1, ALUOutLatch, ALUOutEn}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cmp = 1;
        #3;

        // reset during LATCH
        rsp_ready = 1'b1;
        send(3'd0, 16'h1111, 16'h2222, t0);
        ticks(2);
        chk("pre_rst_latch", {15'd0, ALUOutLatch}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("mid_rst_outputs", {busOut[12:0], opControl}, 16'd0);
        chk("mid_rst_strobes", {11'd0, rsp_valid, ALUin0, ALUin1, ALUOutLatch, ALUOutEn}, 16'd0);
        chk("mid_rst_ops_done", ops_done, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        ticks(6);
        chk("post_rst_no_rsp", {15'd0, rsp_valid}, 16'd0);
        chk("post_rst_ops_done", ops_done, 16'd0);

        // single op
        send(3'd0, 16'h1234, 16'h0F0F, t0);
        ticks(3);
        chk("single_not_yet_valid", {15'd0, rsp_valid}, 16'd0);
        ticks(1);
        chk("single_valid_4_edges", {15'd0, rsp_valid}, 16'd1);
        chk("single_data", rsp_data, 16'h2143);
        chk("single_op", {13'd0, rsp_op}, 16'd0);
        ticks(1);
        chk("single_ops_done", ops_done, 16'd1);

        // backpressure
        rsp_ready = 1'b0;
        send(3'd1, 16'h0005, 16'h0007, t0);
        ticks(4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", {15'd0, rsp_valid}, 16'd1);
            chk("bp_data_stable", rsp_data, 16'hFFFE);
            chk("bp_cmd_ready_low", {15'd0, cmd_ready}, 16'd0);
            chk("bp_ops_done", ops_done, 16'd1);
            ticks(1);
        end
        rsp_ready = 1'b1;
        ticks(2);
        chk("bp_release_once", ops_done, 16'd2);

        // back-to-back
        n0 = rsp_q.size();
        send(3'd0, 16'd1, 16'd1, t0);
        send(3'd1, 16'd9, 16'd4, t1);
        chk("b2b_interval", 16'(t1 - t0), 16'd6);
        for (int i = 0; i < 20 && rsp_q.size() < n0 + 2; i++) ticks(1);
        chk("b2b_count", 16'(rsp_q.size() - n0), 16'd2);
        if (rsp_q.size() >= n0 + 2) begin
            chk("b2b_first", rsp_q[n0], 16'h0002);
            chk("b2b_second", rsp_q[n0 + 1], 16'h0005);
        end

        // randomized traffic with random consumer stalls and idle gaps
        rand_rdy = 1;
        for (int k = 0; k < 40; k++) begin
            send(3'($urandom), 16'($urandom), 16'($urandom), t0);
            ticks(int'($urandom_range(0, 3)));
        end
        drain();

        // counter wrap
        force dut.ops_done = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.ops_done;
        #1;
        chk("wrap_preload", ops_done, 16'hFFFF);
        send(3'd2, 16'h00F0, 16'h0FF0, t0);
        ticks(5);
        chk("wrap_to_zero", ops_done, 16'h0000);
        chk("wrap_data", rsp_data, 16'h0F00);
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
